// File: rtl/posit_mul_arb_if.sv
// Requester, response and shared posit_mul signals for posit_mul_arb.
// slave is the arbiter side; master is the requester/multiplier side.
interface posit_mul_arb_if;
  localparam int unsigned DW = 32;

  logic          req0_valid;
  logic          req1_valid;
  logic          req0_ready;
  logic          req1_ready;
  logic [DW-1:0] req0_a;
  logic [DW-1:0] req0_b;
  logic [DW-1:0] req1_a;
  logic [DW-1:0] req1_b;

  logic          rsp0_valid;
  logic          rsp1_valid;
  logic          rsp0_ready;
  logic          rsp1_ready;
  logic [DW-1:0] rsp0_data;
  logic [DW-1:0] rsp1_data;
  logic          rsp0_nar;
  logic          rsp0_zero;
  logic          rsp0_err;
  logic          rsp1_nar;
  logic          rsp1_zero;
  logic          rsp1_err;

  logic          mul_start;
  logic [DW-1:0] mul_a;
  logic [DW-1:0] mul_b;
  logic [DW-1:0] mul_result;
  logic          mul_done;
  logic          mul_nar;
  logic          mul_zero;

  modport slave (
    input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp1_valid, rsp0_data, rsp1_data,
    output rsp0_nar, rsp0_zero, rsp0_err, rsp1_nar, rsp1_zero, rsp1_err,
    input  rsp0_ready, rsp1_ready,
    output mul_start, mul_a, mul_b,
    input  mul_result, mul_done, mul_nar, mul_zero
  );

  modport master (
    output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp1_valid, rsp0_data, rsp1_data,
    input  rsp0_nar, rsp0_zero, rsp0_err, rsp1_nar, rsp1_zero, rsp1_err,
    output rsp0_ready, rsp1_ready,
    input  mul_start, mul_a, mul_b,
    output mul_result, mul_done, mul_nar, mul_zero
  );
endinterface

// File: rtl/posit_mul_arb.sv
// Two-requester round-robin front end for one shared posit multiplier,
// with a done-timeout that returns NaR plus an error flag.
module posit_mul_arb #(
  parameter int unsigned MAX_WAIT = 64
) (
  input logic              clk,
  input logic              rst_n,
  posit_mul_arb_if.slave   bus
);
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 16;
  localparam logic [DW-1:0] NAR_VAL = 32'h8000_0000;

  typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

  state_t        r_state;
  logic          r_last;
  logic          r_owner;
  logic          r_start;
  logic          r_rsp0_valid;
  logic          r_rsp1_valid;
  logic          r_nar;
  logic          r_zero;
  logic          r_err;
  logic [DW-1:0] r_a;
  logic [DW-1:0] r_b;
  logic [DW-1:0] r_data;
  logic [CW-1:0] r_cnt;

  logic w_grant0;
  logic w_grant1;
  logic w_ready0;
  logic w_ready1;
  logic w_rsp_take;
  logic w_timeout;

  // Ready must follow valid in the same cycle so a request can land on the
  // first cycle out of reset; r_last == 1 favours requester 0 on a tie.
  always_comb begin
    w_grant0   = bus.req0_valid && (!bus.req1_valid || r_last);
    w_grant1   = bus.req1_valid && (!bus.req0_valid || !r_last);
    w_ready0   = rst_n && (r_state == IDLE) && w_grant0;
    w_ready1   = rst_n && (r_state == IDLE) && w_grant1;
    w_rsp_take = r_owner ? (r_rsp1_valid && bus.rsp1_ready)
                         : (r_rsp0_valid && bus.rsp0_ready);
    w_timeout  = (r_cnt == CW'(MAX_WAIT - 1));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_last       <= 1'b1;
      r_owner      <= 1'b0;
      r_start      <= 1'b0;
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
      r_nar        <= 1'b0;
      r_zero       <= 1'b0;
      r_err        <= 1'b0;
      r_a          <= '0;
      r_b          <= '0;
      r_data       <= '0;
      r_cnt        <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_ready0 || w_ready1) begin
            r_owner <= w_ready1;
            r_a     <= w_ready1 ? bus.req1_a : bus.req0_a;
            r_b     <= w_ready1 ? bus.req1_b : bus.req0_b;
            r_start <= 1'b1;
            r_state <= START;
          end
        end
        START: begin
          r_start <= 1'b0;
          r_cnt   <= '0;
          r_state <= WAIT;
        end
        WAIT: begin
          // A done arriving on the timeout cycle still delivers the real product.
          if (bus.mul_done) begin
            r_data       <= bus.mul_result;
            r_nar        <= bus.mul_nar;
            r_zero       <= bus.mul_zero;
            r_err        <= 1'b0;
            r_rsp0_valid <= ~r_owner;
            r_rsp1_valid <= r_owner;
            r_state      <= RESP;
          end else if (w_timeout) begin
            r_data       <= NAR_VAL;
            r_nar        <= 1'b1;
            r_zero       <= 1'b0;
            r_err        <= 1'b1;
            r_rsp0_valid <= ~r_owner;
            r_rsp1_valid <= r_owner;
            r_state      <= RESP;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        RESP: begin
          if (w_rsp_take) begin
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_last       <= r_owner;
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.req0_ready = w_ready0;
  assign bus.req1_ready = w_ready1;
  assign bus.mul_start  = r_start;
  assign bus.mul_a      = r_a;
  assign bus.mul_b      = r_b;
  assign bus.rsp0_valid = r_rsp0_valid;
  assign bus.rsp1_valid = r_rsp1_valid;
  assign bus.rsp0_data  = r_data;
  assign bus.rsp1_data  = r_data;
  assign bus.rsp0_nar   = r_nar;
  assign bus.rsp1_nar   = r_nar;
  assign bus.rsp0_zero  = r_zero;
  assign bus.rsp1_zero  = r_zero;
  assign bus.rsp0_err   = r_err;
  assign bus.rsp1_err   = r_err;

endmodule
